reaction_display: RTL and testbench

- Downstream consumer of the reaction timer.
- Takes the running time, final time and game state, converts the selected 14-bit millisecond value to four BCD digits with an iterative double-dabble engine, and drives four active-low 7-segment displays.
- Optionally tracks the best (minimum) valid reaction time across rounds.

---
 rtl/reaction_display.sv | 257 +++++++++++++++++++++++++
 tb/tb_reaction_display.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_display.sv
// reaction_display: converts the reaction timer's running/final millisecond
// value to four BCD digits with a serial double-dabble engine and drives four
// active-low 7-segment displays (bit0=a .. bit6=g, oHEX0 = ones digit).
//
// Optional feature macro: REACT_BEST_EN
//   Defined   - tracks the best (minimum) valid reaction time, exposes it on
//               oBEST, pulses oNEW_BEST on improvement, and shows it in IDLE
//               when iSHOW_BEST is high.
//   Undefined - those ports and the best-time logic are absent; IDLE blanks.
//
// MAX_VALUE must not exceed 9999: the clamp keeps the thousands digit below 5
// before every shift, which lets the engine skip adjusting the top nibble.
module reaction_display #(
  parameter int unsigned LEAD_ZERO_BLANK = 0,
  parameter int unsigned MAX_VALUE       = 9999
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [13:0] iTIME,
  input  logic [13:0] iFINAL,
  input  logic [1:0]  iSTATE,
`ifdef REACT_BEST_EN
  input  logic        iSHOW_BEST,
  output logic [13:0] oBEST,
  output logic        oNEW_BEST,
`endif
  output logic [6:0]  oHEX0,
  output logic [6:0]  oHEX1,
  output logic [6:0]  oHEX2,
  output logic [6:0]  oHEX3,
  output logic        oBUSY
);

  localparam int unsigned VAL_W    = 14;
  localparam int unsigned BCD_W    = 16;
  localparam int unsigned CNT_W    = 4;
  localparam logic [VAL_W-1:0] MAX_VAL    = VAL_W'(MAX_VALUE);
  localparam logic [VAL_W-1:0] LAST_RST   = 14'h3FFF;
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(VAL_W - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam bit LZB = (LEAD_ZERO_BLANK != 0);

  typedef enum logic [1:0] {
    MODE_BLANK,
    MODE_DASH,
    MODE_NUM
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_COMMIT
  } eng_e;

  // Double-dabble correction for one BCD nibble
  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // Active-low segment pattern for one decimal digit
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  mode_e            w_mode;
  logic [VAL_W-1:0] w_src;
  logic [VAL_W-1:0] w_value;

  eng_e             r_state;
  logic [VAL_W-1:0] r_bin;
  logic [VAL_W-1:0] r_cap;
  logic [VAL_W-1:0] r_last;
  logic [BCD_W-1:0] r_bcd;
  logic [BCD_W-1:0] r_digits;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  logic [3:0]       w_a0;
  logic [3:0]       w_a1;
  logic [3:0]       w_a2;

  logic             w_b3;
  logic             w_b2;
  logic             w_b1;
  logic [6:0]       r_hex0;
  logic [6:0]       r_hex1;
  logic [6:0]       r_hex2;
  logic [6:0]       r_hex3;

`ifdef REACT_BEST_EN
  logic             r_prev_final;
  logic [VAL_W-1:0] r_best;
  logic             r_new_best;
`endif

  // Display mode and numeric source selected by the timer state
  always_comb begin
    w_mode = MODE_BLANK;
    w_src  = iTIME;
    case (iSTATE)
      2'd0: begin
`ifdef REACT_BEST_EN
        if (iSHOW_BEST) begin
          if (r_best == MAX_VAL) begin
            w_mode = MODE_DASH;
          end else begin
            w_mode = MODE_NUM;
            w_src  = r_best;
          end
        end
`endif
      end
      2'd1: w_mode = MODE_DASH;
      2'd2: begin
        w_mode = MODE_NUM;
        w_src  = iTIME;
      end
      default: begin
        w_mode = MODE_NUM;
        w_src  = iFINAL;
      end
    endcase
  end

  // Clamp to the display ceiling
  assign w_value = (w_src > MAX_VAL) ? MAX_VAL : w_src;

  // Corrected lower three nibbles; the thousands nibble never needs correcting
  assign w_a0 = dd_adj(r_bcd[3:0]);
  assign w_a1 = dd_adj(r_bcd[7:4]);
  assign w_a2 = dd_adj(r_bcd[11:8]);

  // Conversion engine: value captured on entry to LOAD, 14 shifts, commit
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state  <= S_IDLE;
      r_bin    <= '0;
      r_cap    <= '0;
      r_last   <= LAST_RST;
      r_bcd    <= '0;
      r_digits <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((w_mode == MODE_NUM) && (w_value != r_last)) begin
            r_bin   <= w_value;
            r_cap   <= w_value;
            r_bcd   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_cnt   <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_bcd <= {r_bcd[14:12], w_a2, w_a1, w_a0, r_bin[VAL_W-1]};
          r_bin <= {r_bin[VAL_W-2:0], 1'b0};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == SHIFT_LAST) begin
            r_state <= S_COMMIT;
          end
        end
        default: begin
          r_digits <= r_bcd;
          r_last   <= r_cap;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  // Leading-zero blanking chain; the ones digit is never blanked
  assign w_b3 = LZB && (r_digits[15:12] == 4'd0);
  assign w_b2 = w_b3 && (r_digits[11:8] == 4'd0);
  assign w_b1 = w_b2 && (r_digits[7:4] == 4'd0);

  // Registered segment outputs
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_hex0 <= SEG_BLANK;
      r_hex1 <= SEG_BLANK;
      r_hex2 <= SEG_BLANK;
      r_hex3 <= SEG_BLANK;
    end else begin
      case (w_mode)
        MODE_NUM: begin
          r_hex0 <= seg7(r_digits[3:0]);
          r_hex1 <= w_b1 ? SEG_BLANK : seg7(r_digits[7:4]);
          r_hex2 <= w_b2 ? SEG_BLANK : seg7(r_digits[11:8]);
          r_hex3 <= w_b3 ? SEG_BLANK : seg7(r_digits[15:12]);
        end
        MODE_DASH: begin
          r_hex0 <= SEG_DASH;
          r_hex1 <= SEG_DASH;
          r_hex2 <= SEG_DASH;
          r_hex3 <= SEG_DASH;
        end
        default: begin
          r_hex0 <= SEG_BLANK;
          r_hex1 <= SEG_BLANK;
          r_hex2 <= SEG_BLANK;
          r_hex3 <= SEG_BLANK;
        end
      endcase
    end
  end

`ifdef REACT_BEST_EN
  // Best-time tracker: samples iTIME on entry to FINAL (iFINAL lags a cycle)
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_prev_final <= 1'b0;
      r_best       <= MAX_VAL;
      r_new_best   <= 1'b0;
    end else begin
      r_prev_final <= (iSTATE == 2'd3);
      r_new_best   <= 1'b0;
      if ((iSTATE == 2'd3) && !r_prev_final &&
          (iTIME < MAX_VAL) && (iTIME < r_best)) begin
        r_best     <= iTIME;
        r_new_best <= 1'b1;
      end
    end
  end

  assign oBEST     = r_best;
  assign oNEW_BEST = r_new_best;
`endif

  assign oHEX0 = r_hex0;
  assign oHEX1 = r_hex1;
  assign oHEX2 = r_hex2;
  assign oHEX3 = r_hex3;
  assign oBUSY = r_busy;

endmodule

// File: tb/tb_reaction_display.sv
// Testbench for reaction_display (LEAD_ZERO_BLANK=1). Expected display words
// are pushed when a conversion is triggered and popped one cycle after oBUSY
// falls. REACT_BEST_EN adds the best-time rounds.
module tb_reaction_display;

  localparam int unsigned LZB  = 1;
  localparam int          MAXV = 9999;
  localparam logic [27:0] ALL_BLANK = {4{7'h7F}};
  localparam logic [27:0] ALL_DASH  = {4{7'h3F}};

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic [13:0] iTIME;
  logic [13:0] iFINAL;
  logic [1:0]  iSTATE;
  logic [6:0]  oHEX0, oHEX1, oHEX2, oHEX3;
  logic        oBUSY;
`ifdef REACT_BEST_EN
  logic        iSHOW_BEST;
  logic [13:0] oBEST;
  logic        oNEW_BEST;
  int          rounds [4] = '{300, 250, 9999, 280};
`endif

  logic [27:0] w_hex;
  assign w_hex = {oHEX3, oHEX2, oHEX1, oHEX0};

  int          n_checks = 0;
  int          n_errors = 0;
  logic [27:0] sb_q [$];

  reaction_display #(
    .LEAD_ZERO_BLANK(LZB),
    .MAX_VALUE      (MAXV)
  ) dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iTIME     (iTIME),
    .iFINAL    (iFINAL),
    .iSTATE    (iSTATE),
`ifdef REACT_BEST_EN
    .iSHOW_BEST(iSHOW_BEST),
    .oBEST     (oBEST),
    .oNEW_BEST (oNEW_BEST),
`endif
    .oHEX0     (oHEX0),
    .oHEX1     (oHEX1),
    .oHEX2     (oHEX2),
    .oHEX3     (oHEX3),
    .oBUSY     (oBUSY)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference display word {HEX3,HEX2,HEX1,HEX0} for a numeric value
  function automatic logic [27:0] exp_hex(input int v);
    int c, d3, d2, d1, d0;
    logic [6:0] h3, h2, h1, h0;
    c  = (v > MAXV) ? MAXV : v;
    d3 = c / 1000;
    d2 = (c / 100) % 10;
    d1 = (c / 10) % 10;
    d0 = c % 10;
    h3 = seg(d3);
    h2 = seg(d2);
    h1 = seg(d1);
    h0 = seg(d0);
    if (LZB != 0) begin
      if (d3 == 0) h3 = 7'h7F;
      if (d3 == 0 && d2 == 0) h2 = 7'h7F;
      if (d3 == 0 && d2 == 0 && d1 == 0) h1 = 7'h7F;
    end
    return {h3, h2, h1, h0};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  // Waits for one conversion to start and finish; returns busy length
  task automatic wait_conv(output int busy_len);
    int n;
    n = 0;
    busy_len = 0;
    while (!oBUSY && n < 8) begin
      @(negedge iCLK);
      n++;
    end
    if (!oBUSY) begin
      check("busy_rise_timeout", 32'(oBUSY), 32'd1);
      return;
    end
    while (oBUSY && busy_len < 40) begin
      @(negedge iCLK);
      busy_len++;
    end
    if (oBUSY) check("busy_fall_timeout", 32'(oBUSY), 32'd0);
    cyc(2);
  endtask

  // Scoreboard monitor: compare display one cycle after each commit
  logic mon_prev = 1'b0;
  logic mon_pend = 1'b0;
  initial begin
    logic [27:0] e;
    forever begin
      @(negedge iCLK);
      if (mon_pend) begin
        mon_pend = 1'b0;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_commit", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check("sb_hex", 32'(w_hex), 32'(e));
        end
      end
      if (iRST_N && mon_prev && !oBUSY) mon_pend = 1'b1;
      mon_prev = oBUSY;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int blen;
    int n;
`ifdef REACT_BEST_EN
    int   bm;
    logic exp_nb;
    iSHOW_BEST = 1'b0;
`endif
    iRST_N = 1'b0;
    iSTATE = 2'd0;
    iTIME  = '0;
    iFINAL = '0;
    cyc(3);
    check("rst_hex", 32'(w_hex), 32'(ALL_BLANK));
    check("rst_busy", 32'(oBUSY), 32'd0);
    iRST_N = 1'b1;
    cyc(2);
    check("idle_blank", 32'(w_hex), 32'(ALL_BLANK));
    check("idle_busy", 32'(oBUSY), 32'd0);

    // Dash mode
    iSTATE = 2'd1;
    cyc(1);
    check("dash", 32'(w_hex), 32'(ALL_DASH));
    cyc(4);
    check("dash_busy", 32'(oBUSY), 32'd0);

    // First conversion: 1234 on iFINAL
    iFINAL = 14'd1234;
    iSTATE = 2'd3;
    sb_q.push_back(exp_hex(1234));
    cyc(1);
    check("pre_commit_zero", 32'(w_hex), 32'(exp_hex(0)));
    wait_conv(blen);
    check("busy_len", 32'(blen), 32'd16);

    // Clamp
    iFINAL = 14'd12000;
    sb_q.push_back(exp_hex(12000));
    wait_conv(blen);
    check("clamp_busy_len", 32'(blen), 32'd16);

    // Stepping iTIME with leading-zero blanking
    iSTATE = 2'd2;
    for (int v = 0; v < 3; v++) begin
      iTIME = 14'(v);
      sb_q.push_back(exp_hex(v));
      n = 0;
      while (w_hex !== exp_hex(v) && n < 40) begin
        @(negedge iCLK);
        n++;
      end
      check("upd_latency", 32'((n - 1 >= 16) && (n - 1 <= 17)), 32'd1);
      if (n < 20) cyc(20 - n);
    end

    // Source change mid-SHIFT
    iTIME = 14'd500;
    sb_q.push_back(exp_hex(500));
    n = 0;
    while (!oBUSY && n < 8) begin
      @(negedge iCLK);
      n++;
    end
    cyc(4);
    iTIME = 14'd501;
    sb_q.push_back(exp_hex(501));
    wait_conv(blen);
    wait_conv(blen);
    check("mid_final", 32'(w_hex), 32'(exp_hex(501)));

    // Switch to dash during a conversion: commit stays silent
    iTIME = 14'd777;
    cyc(3);
    iSTATE = 2'd1;
    sb_q.push_back(ALL_DASH);
    cyc(1);
    check("dash_mid_conv", 32'(w_hex), 32'(ALL_DASH));
    wait_conv(blen);
    iSTATE = 2'd2;
    cyc(1);
    check("resume_hex", 32'(w_hex), 32'(exp_hex(777)));
    check("resume_busy", 32'(oBUSY), 32'd0);
    iSTATE = 2'd0;
    cyc(1);
    check("blank_switch", 32'(w_hex), 32'(ALL_BLANK));

    // Reset mid-conversion
    iSTATE = 2'd2;
    iTIME  = 14'd4321;
    cyc(5);
    iRST_N = 1'b0;
    cyc(1);
    check("rst_abort_busy", 32'(oBUSY), 32'd0);
    check("rst_abort_hex", 32'(w_hex), 32'(ALL_BLANK));
    iRST_N = 1'b1;
    sb_q.push_back(exp_hex(4321));
    cyc(1);
    check("rst_digits_zero", 32'(w_hex), 32'(exp_hex(0)));
    wait_conv(blen);
    check("rst_conv_len", 32'(blen), 32'd16);

`ifdef REACT_BEST_EN
    // Best-time rounds
    check("best_rst", 32'(oBEST), 32'(MAXV));
    iSTATE = 2'd0;
    iSHOW_BEST = 1'b1;
    cyc(1);
    check("best_none_dash", 32'(w_hex), 32'(ALL_DASH));
    iSHOW_BEST = 1'b0;
    iSTATE = 2'd1;
    cyc(1);
    bm = MAXV;
    foreach (rounds[i]) begin
      iSTATE = 2'd2;
      iTIME  = 14'(rounds[i]);
      iFINAL = 14'(rounds[i]);
      sb_q.push_back(exp_hex(rounds[i]));
      wait_conv(blen);
      iSTATE = 2'd3;
      exp_nb = (rounds[i] < MAXV) && (rounds[i] < bm);
      if (exp_nb) bm = rounds[i];
      cyc(1);
      check("new_best", 32'(oNEW_BEST), 32'(exp_nb));
      cyc(1);
      check("new_best_end", 32'(oNEW_BEST), 32'd0);
      iSTATE = 2'd1;
      cyc(1);
    end
    check("best_val", 32'(oBEST), 32'(bm));
    iSTATE = 2'd0;
    iSHOW_BEST = 1'b1;
    sb_q.push_back(exp_hex(250));
    wait_conv(blen);
    check("best_show", 32'(w_hex), 32'(exp_hex(250)));
`endif

    cyc(3);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
